// File: rtl/wb_mdio_master_if.sv
// Wishbone classic single-beat bus bundle for wb_mdio_master.
// slave modport: the peripheral side (address/data/control in, read data/ack out).
// master modport: the CPU/interconnect side.
interface wb_mdio_master_if;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_mdio_master.sv
// Wishbone-slave MDIO (clause 22) management master. One PHY register read or write per
// CMD write; generates MDC and drives MDIO with an output enable (pad tri-state lives at top).
// Ports:
//   wb_clk, wb_rst     : system clock, asynchronous active-high reset
//   bus                : Wishbone slave (CMD 0x0, WDATA 0x4, RDATA 0x8, STATUS 0xC)
//   irq_o              : level interrupt, registered done & ie
//   mdc_o              : MDIO clock, f_wb / (2*CLK_DIV)
//   mdio_o, mdio_oe    : MDIO output data and output enable
//   mdio_i             : MDIO input, already synchronised
module wb_mdio_master #(
  parameter int unsigned CLK_DIV     = 10,
  parameter int unsigned PREAMBLE_EN = 1
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  wb_mdio_master_if.slave        bus,
  output logic                   irq_o,
  output logic                   mdc_o,
  output logic                   mdio_o,
  output logic                   mdio_oe,
  input  logic                   mdio_i
);

  localparam int unsigned     DivW    = $clog2(2 * CLK_DIV);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StEnd} state_e;

  state_e            state_q, state_d;
  logic [4:0]        bit_q, bit_d;
  logic [DivW-1:0]   div_q;
  logic              mdc_q, mdio_q, oe_q;
  logic              ack_q;
  logic [31:0]       dat_q, rd_data;
  logic [10:0]       cmd_q, cmd_nx;
  logic [15:0]       wdata_q, rdata_q, shift_q;
  logic              done_q, nack_q, ovr_q, ie_q, irq_q;
  logic              drive_o, drive_oe;

  logic req, wr, wr_cmd, wr_wdata, wr_status;
  logic busy, period_end, complete, start, sample, nack_set;
  logic unused_bits;

  assign unused_bits = ^{bus.wb_sel_i, bus.wb_adr_i[1:0], bus.wb_dat_i[31:16]};

  // Request decode: ack one cycle after cyc&stb; writes land on the edge closing the ack cycle.
  assign req       = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign wr        = ack_q & bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
  assign wr_cmd    = wr & (bus.wb_adr_i[3:2] == 2'd0);
  assign wr_wdata  = wr & (bus.wb_adr_i[3:2] == 2'd1);
  assign wr_status = wr & (bus.wb_adr_i[3:2] == 2'd3);

  assign busy       = (state_q != StIdle);
  assign period_end = busy & (div_q == DivLast);
  assign complete   = period_end & (state_q == StEnd);
  // A command arriving on the completion cycle counts as not busy.
  assign start      = wr_cmd & (~busy | complete);
  assign sample     = busy & (div_q == DivHalf);
  assign nack_set   = sample & (state_q == StTa) & (bit_q == 5'd1) & cmd_q[10] & mdio_i;
  assign cmd_nx     = start ? bus.wb_dat_i[10:0] : cmd_q;

  always_comb begin
    rd_data = '0;
    case (bus.wb_adr_i[3:2])
      2'd0:    rd_data[10:0] = cmd_q;
      2'd1:    rd_data[15:0] = wdata_q;
      2'd2:    rd_data[15:0] = rdata_q;
      default: rd_data = {23'd0, ie_q, 4'd0, ovr_q, nack_q, done_q, busy};
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= req ? rd_data : '0;
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= StIdle;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  // FSM next state: advance one bit per MDC period, move on after the last bit of a field.
  always_comb begin
    logic [4:0] last_bit;
    state_d  = state_q;
    bit_d    = bit_q;
    last_bit = 5'd0;
    unique case (state_q)
      StPre:   last_bit = 5'd31;
      StHdr:   last_bit = 5'd13;
      StTa:    last_bit = 5'd1;
      StData:  last_bit = 5'd15;
      default: last_bit = 5'd0;
    endcase
    if (start) begin
      state_d = (PREAMBLE_EN != 0) ? StPre : StHdr;
      bit_d   = '0;
    end else if (period_end) begin
      if (bit_q == last_bit) begin
        bit_d = '0;
        unique case (state_q)
          StPre:   state_d = StHdr;
          StHdr:   state_d = StTa;
          StTa:    state_d = StData;
          StData:  state_d = StEnd;
          default: state_d = StIdle;
        endcase
      end else begin
        bit_d = bit_q + 5'd1;
      end
    end
  end

  // FSM outputs: MDIO value/enable for the bit period about to begin.
  always_comb begin
    logic [13:0] hdr;
    hdr      = {2'b01, (cmd_nx[10] ? 2'b10 : 2'b01), cmd_nx[9:0]};
    drive_oe = 1'b0;
    drive_o  = 1'b1;
    unique case (state_d)
      StPre:  drive_oe = 1'b1;
      StHdr: begin
        drive_oe = 1'b1;
        drive_o  = hdr[4'd13 - bit_d[3:0]];
      end
      StTa: begin
        drive_oe = ~cmd_nx[10];
        drive_o  = cmd_nx[10] | (bit_d == 5'd0);
      end
      StData: begin
        drive_oe = ~cmd_nx[10];
        drive_o  = cmd_nx[10] | wdata_q[4'd15 - bit_d[3:0]];
      end
      default: begin
        drive_oe = 1'b0;
        drive_o  = 1'b1;
      end
    endcase
  end

  // Bit timing: MDC low for the first half-period, high for the second; MDIO moves on MDC fall.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      div_q  <= '0;
      mdc_q  <= 1'b0;
      mdio_q <= 1'b1;
      oe_q   <= 1'b0;
    end else if (start || period_end) begin
      div_q  <= '0;
      mdc_q  <= 1'b0;
      mdio_q <= drive_o;
      oe_q   <= drive_oe;
    end else if (busy) begin
      div_q <= div_q + 1'b1;
      if (div_q == DivHalf) mdc_q <= 1'b1;
    end
  end

  // Registers and status; on conflicting W1C and set in one cycle, the set (written last) wins.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cmd_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (start)    cmd_q   <= bus.wb_dat_i[10:0];
      if (wr_wdata) wdata_q <= bus.wb_dat_i[15:0];
      if (wr_status) begin
        ie_q <= bus.wb_dat_i[8];
        if (bus.wb_dat_i[1]) done_q <= 1'b0;
        if (bus.wb_dat_i[2]) nack_q <= 1'b0;
        if (bus.wb_dat_i[3]) ovr_q  <= 1'b0;
      end
      if (complete)         done_q <= 1'b1;
      if (nack_set)         nack_q <= 1'b1;
      if (wr_cmd && !start) ovr_q  <= 1'b1;
      if (sample && state_q == StData && cmd_q[10]) shift_q <= {shift_q[14:0], mdio_i};
      if (complete && cmd_q[10]) rdata_q <= shift_q;
      irq_q <= done_q & ie_q;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign irq_o        = irq_q;
  assign mdc_o        = mdc_q;
  assign mdio_o       = mdio_q;
  assign mdio_oe      = oe_q;

endmodule

// File: doc/wb_mdio_master.md
Name: wb_mdio_master

Overview:
Wishbone-slave MDIO (IEEE 802.3 clause 22) management controller that lets the CPU configure and poll the Ethernet PHY over enet_mdc/enet_mdio. It sits on the SoC peripheral bus in the wb_clk domain and serialises one PHY register read or write per command. It generates MDC and controls the MDIO output enable. The top level instantiates the tri-state pad: enet_mdio = mdio_oe ? mdio_o : 1'bz.

Parameters:
CLK_DIV, 10, wb_clk cycles per MDC half-period (MDC = f_wb/(2*CLK_DIV)); legal values are >= 2.
PREAMBLE_EN, 1, 1 = send 32-bit all-ones preamble; 0 = suppress preamble.

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  asynchronous, active-high reset
wb_adr_i  in  4  byte address; bits [3:2] select the register
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; ignored, all accesses are full-word
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
irq_o  out  1  interrupt, level
mdc_o  out  1  MDIO clock
mdio_o  out  1  MDIO output data
mdio_oe  out  1  MDIO output enable
mdio_i  in  1  MDIO input, already synchronised at top level

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, irq_o=0, mdc_o=0, mdio_o=1, mdio_oe=0. All registers 0; FSM = IDLE. Reset is asynchronous and aborts any frame immediately.
- Bus timing: wb_ack_o pulses for 1 cycle, one cycle after cyc&stb&!ack. Reads return data in the ack cycle. Writes take effect at the ack edge. Unmapped bits read 0.
- Register map:
  - 0x0 CMD (W): [4:0] REGAD, [9:5] PHYAD, [10] OP (1 = read, 0 = write).
    - Write while !busy: latches the fields and starts a frame.
    - Write while busy: the command is dropped and STATUS.ovr is set.
    - Reads of CMD return the last accepted command.
  - 0x4 WDATA (RW): [15:0] write payload.
  - 0x8 RDATA (RO): [15:0] read result. Updated only at completion of a read frame.
  - 0xC STATUS:
    - [0] busy (RO)
    - [1] done (W1C, sticky)
    - [2] nack (W1C, sticky)
    - [3] ovr (W1C, sticky)
    - [8] ie (RW)
- irq_o = done & ie, registered (asserts 1 cycle after done or ie set).
- Bit timing: a divider counter runs only while busy.
  - Each bit period is 2*CLK_DIV cycles: MDC low for the first CLK_DIV cycles, high for the second CLK_DIV.
  - mdio_o/mdio_oe change only on the cycle MDC goes low.
  - mdio_i is sampled on the cycle mdc_o is set to 1.
- busy rises the cycle after the CMD-write ack. The first bit period begins at that same cycle.
- FSM states and bit counts:
  - IDLE -> PRE (32 bits of 1, oe=1; skipped if PREAMBLE_EN=0)
  - -> HDR (14 bits MSB-first: ST=01, OP = 10 read / 01 write, PHYAD[4:0], REGAD[4:0]; oe=1)
  - -> TA (2 bits)
    - write: drives 1,0.
    - read: oe=0. The second TA sample must be 0; otherwise nack is set and the frame still completes.
  - -> DATA (16 bits MSB-first)
    - write: drives WDATA, oe=1.
    - read: oe=0, shift in mdio_i.
  - -> END (1 bit period: MDC toggles, oe=0, mdio_o=1)
  - -> IDLE.
- Completion, on the END->IDLE transition cycle: busy=0, done=1; RDATA loaded if read.
  - Frame length is (64 or 32 bits) + 1 END bit, times 2*CLK_DIV cycles, from busy rise to busy fall.
  - With defaults, read/write takes 65*20 = 1300 cycles.
- Simultaneous events: if a W1C of done and a completion set occur in the same cycle, set wins. A CMD write accepted on the completion cycle is treated as not busy and is accepted.
- In IDLE: mdc_o=0, mdio_oe=0.

Test Plan:
- Write, PHYAD=1, REGAD=0, WDATA=0x1140, defaults. Sampled MDIO on MDC rising edges must be 32x1, 0101, 00001, 00000, 10, 0001000101000000. Busy high for exactly 1300 cycles, then done=1; oe never drops before END.
- Read, PHYAD=3, REGAD=2; PHY model drives TA0=0 and data 0x1234 after MDC rise. RDATA=0x1234, nack=0, oe=0 throughout TA and DATA.
- Read with no PHY (mdio_i pulled to 1) -> RDATA=0xFFFF, nack=1, done=1. W1C 0x6 clears both.
- ie=1; complete any frame -> irq_o=1. Write STATUS=0x102 -> irq_o=0 the next cycle, ie stays 1.
- CMD write mid-frame -> frame unaltered, ovr=1, and no second frame starts.
- PREAMBLE_EN=0, CLK_DIV=2 -> frame takes 33*4=132 cycles. Assert wb_rst mid-DATA -> mdc_o=0, mdio_oe=0, busy=0 immediately. The next command runs a normal full frame.
